// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: FIFO-buffered bridge between the Wrapper's valid/ready UART port and the strobe/ack UART core, plus the RX pin synchroniser.
`timescale 1ns/1ps
module uart_stream_bridge #(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [DATA_W-1:0]           TX_DATA,
  input  logic                        TX_VALID,
  output logic                        TX_READY,
  output logic [DATA_W-1:0]           RX_DATA,
  output logic                        RX_VALID,
  input  logic                        RX_ACK,
  output logic [DATA_W-1:0]           CORE_TX_DATA,
  output logic                        CORE_TX_STB,
  input  logic                        CORE_TX_ACK,
  input  logic [DATA_W-1:0]           CORE_RX_DATA,
  input  logic                        CORE_RX_STB,
  output logic                        CORE_RX_ACK,
  input  logic                        RX_IN,
  output logic                        RX_SYNC,
  output logic [$clog2(TX_DEPTH):0]   TX_LEVEL,
  output logic [$clog2(RX_DEPTH):0]   RX_LEVEL,
  output logic                        TX_OVERFLOW,
  output logic                        RX_OVERFLOW,
  input  logic                        CLR_OVF
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_LW = RX_AW + 1;
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_LOAD = 2'd1;
  localparam logic [1:0] TX_BUSY = 2'd2;
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wr, tx_rd;
  logic [RX_AW-1:0] rx_wr, rx_rd;
  logic [1:0] tx_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic tx_valid_q, rx_ack_q, core_stb_q;
  logic tx_full, rx_full, tx_rise, ack_rise, rx_rise;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_ovf_set, rx_ovf_set;
  always_comb begin
    tx_full    = TX_LEVEL == TX_LW'(TX_DEPTH);
    rx_full    = RX_LEVEL == RX_LW'(RX_DEPTH);
    TX_READY   = !tx_full;
    RX_VALID   = RX_LEVEL != '0;
    tx_rise    = TX_VALID & ~tx_valid_q;
    ack_rise   = RX_ACK & ~rx_ack_q;
    rx_rise    = CORE_RX_STB & ~core_stb_q;
    tx_push    = (EDGE_MODE ? tx_rise : TX_VALID) & ~tx_full;
    tx_ovf_set = EDGE_MODE & tx_rise & tx_full;
    tx_pop     = tx_state == TX_BUSY && CORE_TX_ACK;
    rx_pop     = (EDGE_MODE ? ack_rise : RX_ACK) & RX_VALID;
    rx_push    = rx_rise & (~rx_full | rx_pop);
    rx_ovf_set = rx_rise & rx_full & ~rx_pop;
    RX_DATA    = RX_VALID ? rx_mem[rx_rd] : '0;
    RX_SYNC    = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr] <= TX_DATA;
    if (rx_push) rx_mem[rx_wr] <= CORE_RX_DATA;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q       <= '1;
      tx_valid_q   <= 1'b0;
      rx_ack_q     <= 1'b0;
      core_stb_q   <= 1'b0;
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      TX_LEVEL     <= '0;
      RX_LEVEL     <= '0;
      tx_state     <= TX_IDLE;
      CORE_TX_DATA <= '0;
      CORE_TX_STB  <= 1'b0;
      CORE_RX_ACK  <= 1'b0;
      TX_OVERFLOW  <= 1'b0;
      RX_OVERFLOW  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      tx_valid_q  <= TX_VALID;
      rx_ack_q    <= RX_ACK;
      core_stb_q  <= CORE_RX_STB;
      CORE_RX_ACK <= rx_rise;
      TX_OVERFLOW <= tx_ovf_set | (TX_OVERFLOW & ~CLR_OVF);
      RX_OVERFLOW <= rx_ovf_set | (RX_OVERFLOW & ~CLR_OVF);
      TX_LEVEL    <= TX_LEVEL + TX_LW'(tx_push) - TX_LW'(tx_pop);
      RX_LEVEL    <= RX_LEVEL + RX_LW'(rx_push) - RX_LW'(rx_pop);
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop) tx_rd <= tx_rd + TX_AW'(1);
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop) rx_rd <= rx_rd + RX_AW'(1);
      // LOAD is the fetch slot of a registered FIFO read before the strobe goes out
      if (tx_state == TX_IDLE && TX_LEVEL != '0) tx_state <= TX_LOAD;
      else if (tx_state == TX_LOAD) begin
        CORE_TX_DATA <= tx_mem[tx_rd];
        CORE_TX_STB  <= 1'b1;
        tx_state     <= TX_BUSY;
      end else if (tx_pop) begin
        CORE_TX_STB <= 1'b0;
        tx_state    <= TX_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb_uart_stream_bridge: directed checks of a level-mode and an edge-mode bridge, both with 4-entry FIFOs.
`timescale 1ns/1ps
module tb_uart_stream_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] a_txd, a_rxd, a_ctd, a_crd, b_txd, b_rxd, b_ctd, b_crd;
  logic a_txv, a_txr, a_rxv, a_rxack, a_cstb, a_cack, a_crstb, a_crack, a_rxin, a_rxsync, a_tovf, a_rovf, a_clr;
  logic b_txv, b_txr, b_rxv, b_rxack, b_cstb, b_cack, b_crstb, b_crack, b_rxin, b_rxsync, b_tovf, b_rovf, b_clr;
  logic [2:0] a_txl, a_rxl, b_txl, b_rxl;
  always #5 clk = ~clk;
  uart_stream_bridge #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .TX_DATA(a_txd), .TX_VALID(a_txv), .TX_READY(a_txr),
    .RX_DATA(a_rxd), .RX_VALID(a_rxv), .RX_ACK(a_rxack), .CORE_TX_DATA(a_ctd), .CORE_TX_STB(a_cstb),
    .CORE_TX_ACK(a_cack), .CORE_RX_DATA(a_crd), .CORE_RX_STB(a_crstb), .CORE_RX_ACK(a_crack),
    .RX_IN(a_rxin), .RX_SYNC(a_rxsync), .TX_LEVEL(a_txl), .RX_LEVEL(a_rxl),
    .TX_OVERFLOW(a_tovf), .RX_OVERFLOW(a_rovf), .CLR_OVF(a_clr));
  uart_stream_bridge #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .TX_DATA(b_txd), .TX_VALID(b_txv), .TX_READY(b_txr),
    .RX_DATA(b_rxd), .RX_VALID(b_rxv), .RX_ACK(b_rxack), .CORE_TX_DATA(b_ctd), .CORE_TX_STB(b_cstb),
    .CORE_TX_ACK(b_cack), .CORE_RX_DATA(b_crd), .CORE_RX_STB(b_crstb), .CORE_RX_ACK(b_crack),
    .RX_IN(b_rxin), .RX_SYNC(b_rxsync), .TX_LEVEL(b_txl), .RX_LEVEL(b_rxl),
    .TX_OVERFLOW(b_tovf), .RX_OVERFLOW(b_rovf), .CLR_OVF(b_clr));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic a_strobe(input logic [7:0] d, input logic exp_ack);
    a_crd = d;
    a_crstb = 1'b1;
    tick();
    chk("a_rx_ack_pulse", a_crack, exp_ack);
    a_crstb = 1'b0;
    tick();
    chk("a_rx_ack_low", a_crack, 1'b0);
  endtask
  task automatic a_pop(input logic [7:0] exp);
    chk("a_rx_head", a_rxd, exp);
    a_rxack = 1'b1;
    tick();
    a_rxack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    {a_txd, a_crd, b_txd, b_crd} = '0;
    {a_txv, a_rxack, a_cack, a_crstb, a_rxin, a_clr} = '0;
    {b_txv, b_rxack, b_cack, b_crstb, b_rxin, b_clr} = '0;
    tick();
    tick();
    chk("rst_tx_ready", a_txr, 1'b1);
    chk("rst_rx_valid", a_rxv, 1'b0);
    chk("rst_rx_data", a_rxd, 8'h00);
    chk("rst_core_tx_data", a_ctd, 8'h00);
    chk("rst_core_tx_stb", a_cstb, 1'b0);
    chk("rst_core_rx_ack", a_crack, 1'b0);
    chk("rst_rx_sync", a_rxsync, 1'b1);
    chk("rst_levels", {a_txl, a_rxl}, 6'd0);
    chk("rst_ovf", {a_tovf, a_rovf}, 2'b00);
    chk("rst_b_rx_sync", b_rxsync, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("sync_lag1", a_rxsync, 1'b1);
    tick();
    chk("sync_lag2", a_rxsync, 1'b0);
    a_txv = 1'b1;
    a_txd = 8'h41;
    tick();
    chk("tx_lvl1", a_txl, 3'd1);
    a_txd = 8'h42;
    tick();
    chk("tx_lvl2", a_txl, 3'd2);
    chk("tx_stb_not_yet", a_cstb, 1'b0);
    a_txd = 8'h43;
    tick();
    chk("tx_lvl3", a_txl, 3'd3);
    chk("tx_stb_first", a_cstb, 1'b1);
    chk("tx_data_first", a_ctd, 8'h41);
    a_txd = 8'h44;
    tick();
    chk("tx_lvl_full", a_txl, 3'd4);
    chk("tx_ready_full", a_txr, 1'b0);
    a_txd = 8'h45;
    tick();
    chk("tx_held_off", a_txl, 3'd4);
    chk("tx_stb_hold", {a_cstb, a_ctd}, {1'b1, 8'h41});
    a_cack = 1'b1;
    tick();
    a_cack = 1'b0;
    chk("tx_stb_drop", a_cstb, 1'b0);
    chk("tx_ready_freed", a_txr, 1'b1);
    chk("tx_lvl_pop", a_txl, 3'd3);
    tick();
    a_txv = 1'b0;
    chk("tx_late_push", a_txl, 3'd4);
    chk("tx_gap_no_stb", a_cstb, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      int n = 0;
      while (!a_cstb && n < 20) begin
        tick();
        n++;
      end
      chk("tx_stb_wait", a_cstb, 1'b1);
      chk("tx_order", a_ctd, 8'h40 + i[7:0]);
      tick();
      tick();
      a_cack = 1'b1;
      tick();
      a_cack = 1'b0;
      chk("tx_stb_release", a_cstb, 1'b0);
    end
    tick();
    tick();
    chk("tx_drained", a_txl, 3'd0);
    chk("tx_no_ovf", a_tovf, 1'b0);
    a_strobe(8'h10, 1'b1);
    chk("rx_first_level", {a_rxv, a_rxl}, {1'b1, 3'd1});
    for (int i = 1; i < 6; i++) a_strobe(8'h10 + i[7:0], 1'b1);
    chk("rx_level_full", a_rxl, 3'd4);
    chk("rx_ovf_set", a_rovf, 1'b1);
    for (int i = 0; i < 4; i++) a_pop(8'h10 + i[7:0]);
    chk("rx_empty", {a_rxv, a_rxd, a_rxl}, 12'h000);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("rx_ovf_clr", a_rovf, 1'b0);
    for (int i = 0; i < 4; i++) a_strobe(8'h20 + i[7:0], 1'b1);
    chk("rx_refill", a_rxl, 3'd4);
    chk("rx_full_head", a_rxd, 8'h20);
    a_crd = 8'hAA;
    a_crstb = 1'b1;
    a_rxack = 1'b1;
    tick();
    a_crstb = 1'b0;
    a_rxack = 1'b0;
    chk("rx_pushpop_level", a_rxl, 3'd4);
    chk("rx_pushpop_ovf", a_rovf, 1'b0);
    for (int i = 1; i < 4; i++) a_pop(8'h20 + i[7:0]);
    chk("rx_aa_last", {a_rxl, a_rxd}, {3'd1, 8'hAA});
    a_pop(8'hAA);
    b_txd = 8'h55;
    b_txv = 1'b1;
    repeat (10) tick();
    b_txv = 1'b0;
    chk("edge_tx_one", b_txl, 3'd1);
    chk("edge_tx_stb", {b_cstb, b_ctd}, {1'b1, 8'h55});
    tick();
    for (int i = 0; i < 3; i++) begin
      b_txd = 8'h60 + i[7:0];
      b_txv = 1'b1;
      tick();
      b_txv = 1'b0;
      tick();
    end
    chk("edge_tx_fill", {b_txl, b_tovf}, {3'd4, 1'b0});
    b_txd = 8'h63;
    b_txv = 1'b1;
    tick();
    b_txv = 1'b0;
    tick();
    chk("edge_tx_ovf", {b_txl, b_tovf, b_txr}, {3'd4, 1'b1, 1'b0});
    b_txv = 1'b1;
    b_clr = 1'b1;
    tick();
    b_txv = 1'b0;
    chk("ovf_set_wins", b_tovf, 1'b1);
    tick();
    b_clr = 1'b0;
    chk("ovf_cleared", b_tovf, 1'b0);
    b_crd = 8'h66;
    b_crstb = 1'b1;
    tick();
    b_crstb = 1'b0;
    tick();
    b_crd = 8'h67;
    b_crstb = 1'b1;
    tick();
    b_crstb = 1'b0;
    chk("edge_rx_two", b_rxl, 3'd2);
    b_rxack = 1'b1;
    repeat (5) tick();
    b_rxack = 1'b0;
    chk("edge_rx_one_pop", {b_rxl, b_rxd}, {3'd1, 8'h67});
    for (int i = 0; i < 3; i++) a_strobe(8'h30 + i[7:0], 1'b1);
    a_txv = 1'b1;
    a_txd = 8'h71;
    tick();
    a_txd = 8'h72;
    tick();
    a_txd = 8'h73;
    tick();
    a_txv = 1'b0;
    chk("mid_pre", {a_cstb, a_txl, a_rxl}, {1'b1, 3'd3, 3'd3});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async", {a_cstb, a_txl, a_rxl, a_rxv}, {1'b0, 3'd0, 3'd0, 1'b0});
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_no_stale", {a_cstb, a_txl, a_rxl, a_ctd}, {1'b0, 3'd0, 3'd0, 8'h00});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
